wshb_arbiter_2m: RTL and testbench
==================================

# wshb_arbiter_2m

Two-master Wishbone arbiter sharing the single SDRAM slave port between the video stream reader (master 0) and the frame-buffer writer (master 1). It sits between the two bus masters and `hw_support`'s SDRAM slave interface, in the `sys_clk` (100 MHz) domain. It grants the bus for a full `cyc` tenure and uses round-robin fairness when both masters request.

## Interface
- `DATA_BYTES`, default 4: byte width of all three Wishbone interfaces. All three must match.
- `sys_clk`, input, 1: system clock, 100 MHz.
- `sys_rst`, input, 1: reset, asynchronous, active-high.
- `wshb_ifs0`, `wshb_if.slave`, DATA_BYTES: master 0 (video reader) side.
- `wshb_ifs1`, `wshb_if.slave`, DATA_BYTES: master 1 (writer) side.
- `wshb_ifm`, `wshb_if.master`, DATA_BYTES: connects to the SDRAM slave.
- `grant`, output, 2: one-hot current owner. `00` means idle. Debug / LED use.

## Operation
- FSM states: `IDLE`, `GNT0`, `GNT1`. Registered state; `grant` is decoded from the state.
- `IDLE`:
  - `cyc0 & !cyc1` → `GNT0`.
  - `cyc1 & !cyc0` → `GNT1`.
  - Both asserted → the master that was not served last. `last` resets to 1, so master 0 wins the first tie.
- `GNTx`: hold while `cycx=1`; `stbx` toggling does not release the grant.
- Release of `GNTx` (`cycx=0`):
  - Other master's `cyc=1` → go directly to the other grant state (no idle cycle).
  - Otherwise → `IDLE`.
  - Either way, update `last=x`.
- Forward path (combinational mux on state): `cyc`, `stb`, `we`, `adr`, `dat_ms`, `sel`, `cti`, `bte` of the granted master go to `wshb_ifm`.
- In `IDLE`, all forward outputs are 0.
- `wshb_ifm.cyc` is the granted master's `cyc`, gated by the state. Dropping `cyc` is therefore seen by the slave in the same cycle.
- Return path:
  - `ack`, `err`, `rty` are routed only to the granted master. The non-granted master sees 0 on all three.
  - `dat_sm` is broadcast to both masters.
- No transaction is ever pre-empted. A master may hold the bus indefinitely; fairness applies only at tenure boundaries.

## Timing
- Grant latency: `cycx` asserted in cycle n (bus idle) → `wshb_ifm.cyc=1` in cycle n+1. One registered decision.
- Return latency: `ack`/`err`/`rty`/`dat_sm` from the SDRAM slave reach the granted master in the same cycle (0 latency).
- Handover: master x drops `cyc` in cycle m → the other master is granted in cycle m+1 with `wshb_ifm.cyc` driven.
- Asynchronous reset, including mid-burst:
  - State → `IDLE`, `grant=00`, `last=1` immediately.
  - All `wshb_ifm` forward outputs → 0 and both masters' `ack` → 0, independent of the clock.
- A master that asserts `cyc` while the other holds the bus waits with `ack=0`. It must keep `stb`/`adr` stable (Wishbone rule); the arbiter does not latch them.

## Configuration
- `WSHB_ARB_FIXED_PRIO_EN`:
  - Defined: ties in `IDLE`, and the handover decision, always favour master 0 (the video reader must never starve). `last` is unused.
  - Undefined (default): round-robin as described above.
  - Both modes have identical grant latency.

## Structure
- `wshb_arb_pkg`: `typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t`, plus the `grant` encoding constants.
- Sub-module `arb_rr_core`: contains the FSM, `last`, and the macro-dependent priority logic. Its inputs are `cyc0` and `cyc1`; its outputs are `state` and `grant`.
- The top level holds only the interface muxing.

## Test plan
- Single requester: master 0 issues 4 classic reads to adr `0x100`–`0x10C`. Expect `grant=01` from the cycle after `cyc0`, 4 acks delivered to master 0 only, and `grant=00` one cycle after `cyc0` falls.
- Tie at idle, round-robin: both assert `cyc` in the same cycle right after reset. Expect master 0 first. Then both re-request at idle, and master 1 is granted.
- Back-to-back handover: master 1 requests while master 0 bursts 8 words. Expect master 1 to get `ack=0` throughout, and `grant` to go `01`→`10` with no idle cycle.
- Isolation: during `GNT1`, the slave returns `err=1`. Master 1 sees `err`; master 0 sees `ack=err=rty=0`. `dat_sm=0xDEADBEEF` is visible on both.
- Reset mid-burst: assert `sys_rst` between clock edges during `GNT0`. Expect `wshb_ifm.cyc=0` and `grant=00` before the next edge, and after release the first tie goes to master 0.
- `WSHB_ARB_FIXED_PRIO_EN` defined: three consecutive idle ties. Expect master 0 to win all three.

Source files
------------

// File: rtl/wshb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM state encoding and
// one-hot grant constants, plus the state-to-grant decode.
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // One-hot owner indication derived purely from the registered state.
  function automatic logic [1:0] grant_of(arb_state_t s);
    case (s)
      GNT0:    grant_of = GRANT_M0;
      GNT1:    grant_of = GRANT_M1;
      default: grant_of = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle (classic/registered-feedback signals) with master
// and slave views. DATA_BYTES sets the data and select widths.
interface wshb_if #(
  parameter int DATA_BYTES = 4
);

  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [31:0]             adr;
  logic [8*DATA_BYTES-1:0] dat_ms;
  logic [8*DATA_BYTES-1:0] dat_sm;
  logic [DATA_BYTES-1:0]   sel;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/arb_rr_core.sv
// Arbitration FSM for two Wishbone masters. Grants a whole cyc tenure,
// hands over directly when the other master is waiting, and resolves idle
// ties round-robin via 'last' (the master served most recently).
// Build option: WSHB_ARB_FIXED_PRIO_EN -- when defined, every tie goes to
// master 0 and 'last' is not built.
module arb_rr_core
  import wshb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cyc0,
  input  logic       cyc1,
  output arb_state_t state,
  output logic [1:0] grant
);

  arb_state_t state_q;
  arb_state_t state_d;
  arb_state_t tie_winner;

`ifdef WSHB_ARB_FIXED_PRIO_EN
  // Video reader must never starve: it always wins a simultaneous request.
  assign tie_winner = GNT0;
`else
  logic last_q;
  logic last_d;

  // Whoever was not served last wins a tie; reset value favours master 0.
  assign tie_winner = last_q ? GNT0 : GNT1;

  // Record the owner of each tenure as it ends.
  always_comb begin
    last_d = last_q;
    if (state_q == GNT0 && !cyc0) begin
      last_d = 1'b0;
    end else if (state_q == GNT1 && !cyc1) begin
      last_d = 1'b1;
    end
  end

  // Last-served register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Next-state: hold a grant for the whole cyc tenure, then hand over or idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cyc0 && cyc1) begin
          state_d = tie_winner;
        end else if (cyc0) begin
          state_d = GNT0;
        end else if (cyc1) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!cyc0) begin
          state_d = cyc1 ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!cyc1) begin
          state_d = cyc0 ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any grant immediately, even mid-burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;
  assign grant = grant_of(state_q);

endmodule

// File: rtl/wshb_arbiter_2m.sv
// Two-master Wishbone arbiter in front of the SDRAM slave port.
// Master 0 is the video stream reader, master 1 the frame-buffer writer.
// The arbitration decision lives in arb_rr_core; this level only steers
// the forward and return signals according to the registered state.
// Build option: WSHB_ARB_FIXED_PRIO_EN (see arb_rr_core).
module wshb_arbiter_2m
  import wshb_arb_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  wshb_if.slave      wshb_ifs0,
  wshb_if.slave      wshb_ifs1,
  wshb_if.master     wshb_ifm,
  output logic [1:0] grant
);

  arb_state_t state;

  arb_rr_core u_core (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .cyc0  (wshb_ifs0.cyc),
    .cyc1  (wshb_ifs1.cyc),
    .state (state),
    .grant (grant)
  );

  // Forward mux: granted master drives the slave; idle drives all zeros.
  // cyc passes straight through so a dropped cyc reaches the slave at once.
  always_comb begin
    wshb_ifm.cyc    = 1'b0;
    wshb_ifm.stb    = 1'b0;
    wshb_ifm.we     = 1'b0;
    wshb_ifm.adr    = 32'd0;
    wshb_ifm.dat_ms = {8*DATA_BYTES{1'b0}};
    wshb_ifm.sel    = {DATA_BYTES{1'b0}};
    wshb_ifm.cti    = 3'd0;
    wshb_ifm.bte    = 2'd0;
    case (state)
      GNT0: begin
        wshb_ifm.cyc    = wshb_ifs0.cyc;
        wshb_ifm.stb    = wshb_ifs0.stb;
        wshb_ifm.we     = wshb_ifs0.we;
        wshb_ifm.adr    = wshb_ifs0.adr;
        wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
        wshb_ifm.sel    = wshb_ifs0.sel;
        wshb_ifm.cti    = wshb_ifs0.cti;
        wshb_ifm.bte    = wshb_ifs0.bte;
      end
      GNT1: begin
        wshb_ifm.cyc    = wshb_ifs1.cyc;
        wshb_ifm.stb    = wshb_ifs1.stb;
        wshb_ifm.we     = wshb_ifs1.we;
        wshb_ifm.adr    = wshb_ifs1.adr;
        wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
        wshb_ifm.sel    = wshb_ifs1.sel;
        wshb_ifm.cti    = wshb_ifs1.cti;
        wshb_ifm.bte    = wshb_ifs1.bte;
      end
      default: ;
    endcase
  end

  // Return path to master 0: handshake only while it owns the bus.
  always_comb begin
    wshb_ifs0.ack = (state == GNT0) && wshb_ifm.ack;
    wshb_ifs0.err = (state == GNT0) && wshb_ifm.err;
    wshb_ifs0.rty = (state == GNT0) && wshb_ifm.rty;
  end

  // Return path to master 1: handshake only while it owns the bus.
  always_comb begin
    wshb_ifs1.ack = (state == GNT1) && wshb_ifm.ack;
    wshb_ifs1.err = (state == GNT1) && wshb_ifm.err;
    wshb_ifs1.rty = (state == GNT1) && wshb_ifm.rty;
  end

  // Read data needs no qualification; ack tells each master when it is valid.
  assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
  assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;

endmodule

// File: tb/tb_wshb_arbiter_2m.sv
// Directed bench for wshb_arbiter_2m: two bench-driven masters, a simple
// registered-ack SDRAM slave model, and a read-data scoreboard.
// Honours WSHB_ARB_FIXED_PRIO_EN for tie expectations.
module tb_wshb_arbiter_2m;

  logic       clk;
  logic       rst;
  logic [1:0] grant;
  logic       err_mode;

  int nerr = 0;
  int nchk = 0;
  int last_m = 1;
  int ack_cnt [2];
  logic [31:0] sb [$];

  wshb_if #(.DATA_BYTES(4)) ifs0 ();
  wshb_if #(.DATA_BYTES(4)) ifs1 ();
  wshb_if #(.DATA_BYTES(4)) ifm ();

  wshb_arbiter_2m #(.DATA_BYTES(4)) dut (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .wshb_ifs0 (ifs0),
    .wshb_ifs1 (ifs1),
    .wshb_ifm  (ifm),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_data(logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Slave model: one wait state per classic read, optional error response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ifm.ack <= 1'b0;
    else     ifm.ack <= ifm.cyc & ifm.stb & ~ifm.ack & ~err_mode;
  end
  assign ifm.err    = err_mode & ifm.cyc & ifm.stb;
  assign ifm.rty    = 1'b0;
  assign ifm.dat_sm = err_mode ? 32'hDEADBEEF : exp_data(ifm.adr);

  function automatic int exp_tie();
`ifdef WSHB_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (last_m == 1) ? 0 : 1;
`endif
  endfunction

  function automatic logic [1:0] gnt_code(int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic ack_of(int m);
    return (m == 0) ? ifs0.ack : ifs1.ack;
  endfunction

  function automatic logic [31:0] dat_of(int m);
    return (m == 0) ? ifs0.dat_sm : ifs1.dat_sm;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int m, logic c, logic s, logic [31:0] a);
    if (m == 0) begin
      ifs0.cyc = c; ifs0.stb = s; ifs0.adr = a;
    end else begin
      ifs1.cyc = c; ifs1.stb = s; ifs1.adr = a;
    end
  endtask

  // Classic reads by master m; expected data queued when each address is driven.
  task automatic bus_read(int m, logic [31:0] base, int n);
    logic [31:0] a;
    bit got;
    for (int i = 0; i < n; i++) begin
      a = base + 32'(4 * i);
      got = 1'b0;
      drive(m, 1'b1, 1'b1, a);
      sb.push_back(exp_data(a));
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        chk("other_ack_zero", {31'd0, ack_of(1 - m)}, 32'd0);
        if (ack_of(m)) begin
          got = 1'b1;
          ack_cnt[m]++;
          chk("rd_data", dat_of(m), sb.pop_front());
        end
        step();
      end
      if (!got) chk("ack_timeout", 32'd0, 32'd1);
    end
    drive(m, 1'b1, 1'b0, a);
  endtask

  // Both masters request together from idle; check decision latency and winner.
  task automatic tie_round(int w);
    drive(0, 1'b1, 1'b0, 32'd0);
    drive(1, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("tie_latency_grant", {30'd0, grant}, 32'd0);
    chk("tie_latency_cyc", {31'd0, ifm.cyc}, 32'd0);
    step();
    @(negedge clk);
    chk("tie_winner", {30'd0, grant}, {30'd0, gnt_code(w)});
    chk("tie_cyc", {31'd0, ifm.cyc}, 32'd1);
    step();
  endtask

  // Loser withdraws, winner reads n words, then drops cyc and the bus idles.
  task automatic tenure_solo(int w, logic [31:0] base, int n);
    drive(1 - w, 1'b0, 1'b0, 32'd0);
    bus_read(w, base, n);
    drive(w, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk("drop_cyc_same_cycle", {31'd0, ifm.cyc}, 32'd0);
    chk("drop_grant_held", {30'd0, grant}, {30'd0, gnt_code(w)});
    step();
    @(negedge clk);
    chk("release_to_idle", {30'd0, grant}, 32'd0);
    step();
    last_m = w;
  endtask

  initial begin
    int w;
    int acks_before;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int acks_before;
    rst = 1'b1;
    err_mode = 1'b0;
    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
    ifs0.cyc = 0; ifs0.stb = 0; ifs0.we = 0; ifs0.adr = 0;
    ifs0.dat_ms = 0; ifs0.sel = 4'hF; ifs0.cti = 0; ifs0.bte = 0;
    ifs1.cyc = 0; ifs1.stb = 0; ifs1.we = 0; ifs1.adr = 0;
    ifs1.dat_ms = 0; ifs1.sel = 4'hF; ifs1.cti = 0; ifs1.bte = 0;

    // Reset state, including a request that must be ignored while in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_grant", {30'd0, grant}, 32'd0);
    chk("reset_ifm_cyc", {31'd0, ifm.cyc}, 32'd0);
    ifs0.cyc = 1'b1;
    @(negedge clk);
    chk("reset_ignores_cyc", {30'd0, grant}, 32'd0);
    chk("reset_ifm_cyc_gated", {31'd0, ifm.cyc}, 32'd0);
    ifs0.cyc = 1'b0;
    step();
    rst = 1'b0;
    last_m = 1;

    // Idle tie right after reset, then a re-request tie
    w = exp_tie();
    chk("first_tie_model", w, 0);
    tie_round(w);
    tenure_solo(w, 32'h200, 1);
    w = exp_tie();
    tie_round(w);
    tenure_solo(w, 32'h300, 2);

    // Single requester: four classic reads from master 0
    drive(0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    chk("single_latency", {30'd0, grant}, 32'd0);
    step();
    @(negedge clk);
    chk("single_grant", {30'd0, grant}, 32'h1);
    step();
    acks_before = ack_cnt[0];
    tenure_solo(0, 32'h100, 4);
    chk("single_ack_count", ack_cnt[0] - acks_before, 4);

    // Back-to-back handover while master 1 waits
    drive(0, 1'b1, 1'b0, 32'd0);
    step();
    drive(1, 1'b1, 1'b1, 32'h400);
    acks_before = ack_cnt[1];
    bus_read(0, 32'h500, 8);
    chk("waiting_master_no_ack", ack_cnt[1] - acks_before, 0);
    drive(0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk("handover_cyc_drop", {31'd0, ifm.cyc}, 32'd0);
    chk("handover_grant_old", {30'd0, grant}, 32'h1);
    step();
    @(negedge clk);
    chk("handover_grant_new", {30'd0, grant}, 32'h2);
    chk("handover_cyc_new", {31'd0, ifm.cyc}, 32'd1);
    step();
    last_m = 0;
    bus_read(1, 32'h400, 1);

    // Error isolation during master 1 tenure with master 0 pending
    drive(0, 1'b1, 1'b1, 32'h600);
    drive(1, 1'b1, 1'b1, 32'h700);
    err_mode = 1'b1;
    @(negedge clk);
    chk("iso_grant", {30'd0, grant}, 32'h2);
    chk("iso_m1_err", {31'd0, ifs1.err}, 32'd1);
    chk("iso_m1_ack", {31'd0, ifs1.ack}, 32'd0);
    chk("iso_m0_ack", {31'd0, ifs0.ack}, 32'd0);
    chk("iso_m0_err", {31'd0, ifs0.err}, 32'd0);
    chk("iso_m0_rty", {31'd0, ifs0.rty}, 32'd0);
    chk("iso_m0_dat", ifs0.dat_sm, 32'hDEADBEEF);
    chk("iso_m1_dat", ifs1.dat_sm, 32'hDEADBEEF);
    step();
    err_mode = 1'b0;
    drive(1, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk("iso_release_grant", {30'd0, grant}, 32'h2);
    step();
    @(negedge clk);
    chk("iso_handover_m0", {30'd0, grant}, 32'h1);
    step();
    last_m = 1;
    bus_read(0, 32'h600, 1);
    drive(0, 1'b0, 1'b0, 32'd0);
    step();
    last_m = 0;
    step();

    // Asynchronous reset between edges during a master 0 burst
    drive(0, 1'b1, 1'b1, 32'h800);
    step();
    step();
    #3;
    chk("pre_reset_cyc", {31'd0, ifm.cyc}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_cyc", {31'd0, ifm.cyc}, 32'd0);
    chk("async_rst_stb", {31'd0, ifm.stb}, 32'd0);
    chk("async_rst_adr", ifm.adr, 32'd0);
    chk("async_rst_grant", {30'd0, grant}, 32'd0);
    chk("async_rst_m0_ack", {31'd0, ifs0.ack}, 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0);
    step();
    rst = 1'b0;
    last_m = 1;

    // Three consecutive idle ties after reset
    for (int k = 0; k < 3; k++) begin
      w = exp_tie();
      tie_round(w);
      drive(0, 1'b0, 1'b0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0);
      step();
      last_m = w;
    end
    @(negedge clk);
    chk("final_idle", {30'd0, grant}, 32'd0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
